// File: rtl/gray_sweep_if.sv
// Handshake and data bundle between a sweep requester and the gray_sweep_ctrl sequencer.
// The master drives requests and range configuration; the slave returns index, Gray code and status.
interface gray_sweep_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             stop;
    logic             dir;
    logic             cont;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             step_en;
    logic [WIDTH-1:0] bin_out;
    logic [WIDTH-1:0] gray_out;
    logic             valid;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, stop, dir, cont, lo, hi, step_en,
        input  bin_out, gray_out, valid, busy, done, err
    );

    modport slave (
        input  start, stop, dir, cont, lo, hi, step_en,
        output bin_out, gray_out, valid, busy, done, err
    );
endinterface

// File: rtl/gray_sweep_ctrl.sv
// Sweeps a binary index across a captured [lo, hi] range, up or down, single-shot or wrapping,
// and presents the index together with its registered Gray code and start/stop/done status.
module gray_sweep_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    gray_sweep_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_q;
    logic             dir_q;
    logic             cont_q;

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] gray_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic [WIDTH-1:0] bin_nxt;
    logic [WIDTH-1:0] start_val;
    logic             at_end;

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    assign start_val = dir_q ? hi_q : lo_q;
    assign at_end    = dir_q ? (bin_q == lo_q) : (bin_q == hi_q);

    // Single next-index source so bin_out and gray_out can never disagree.
    always_comb begin
        bin_nxt = bin_q;
        case (state)
            LOAD: begin
                if (!bus.stop) begin
                    bin_nxt = start_val;
                end
            end
            RUN: begin
                if (!bus.stop && bus.step_en) begin
                    if (!at_end) begin
                        bin_nxt = dir_q ? (bin_q - ONE) : (bin_q + ONE);
                    end else if (cont_q) begin
                        bin_nxt = start_val;
                    end
                end
            end
            default: begin
                bin_nxt = bin_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            lo_q    <= '0;
            hi_q    <= '0;
            dir_q   <= 1'b0;
            cont_q  <= 1'b0;
            bin_q   <= '0;
            gray_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            bin_q  <= bin_nxt;
            gray_q <= to_gray(bin_nxt);
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.lo <= bus.hi) begin
                            lo_q   <= bus.lo;
                            hi_q   <= bus.hi;
                            dir_q  <= bus.dir;
                            cont_q <= bus.cont;
                            busy_q <= 1'b1;
                            state  <= LOAD;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (bus.stop) begin
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        valid_q <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    // Abort wins over a coincident step; the index simply freezes.
                    if (bus.stop) begin
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end else if (bus.step_en && at_end && !cont_q) begin
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.bin_out  = bin_q;
    assign bus.gray_out = gray_q;
    assign bus.valid    = valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;

    a_gray_matches_bin : assert property (@(posedge clk) disable iff (!rst_n)
        gray_q == to_gray(bin_q));
    a_valid_implies_busy : assert property (@(posedge clk) disable iff (!rst_n)
        valid_q |-> busy_q);
    a_done_single_cycle : assert property (@(posedge clk) disable iff (!rst_n)
        done_q |=> !done_q);

endmodule

// File: doc/gray_sweep_ctrl.md
Name: gray_sweep_ctrl

Overview:
Sequencer that drives a binary index through a programmable range [lo, hi] and presents both the binary value and its registered Gray-code equivalent. It supports up or down sweeps, single-shot or continuous wrap, and pacing by an external step enable. It is used to stimulate Gray-coded position/pointer paths in the design with a start/stop/done handshake.

Parameters:
WIDTH, 4, bit width of the index, range bounds and Gray output

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  reset; one clock; reset is asynchronous and active-low
start  input  1  request a sweep; sampled only in IDLE
stop  input  1  abort the active sweep; sampled in LOAD and RUN
dir  input  1  0 = count up from lo, 1 = count down from hi; captured on accepted start
cont  input  1  0 = single sweep then done, 1 = wrap continuously; captured on accepted start
lo  input  WIDTH  lower bound (inclusive), unsigned; captured on accepted start
hi  input  WIDTH  upper bound (inclusive), unsigned; captured on accepted start
step_en  input  1  advance index by one on this edge (RUN only)
bin_out  output  WIDTH  current binary index (registered)
gray_out  output  WIDTH  registered Gray code of bin_out
valid  output  1  bin_out/gray_out belong to an active sweep
busy  output  1  high in LOAD and RUN
done  output  1  one-cycle pulse on natural end of a single sweep
err  output  1  one-cycle pulse when start is rejected for lo > hi

Behaviour:
- Reset (async, rst_n=0): state IDLE; bin_out=0, gray_out=0, valid=0, busy=0, done=0, err=0; shadow lo/hi/dir/cont cleared. Takes effect immediately, including mid-sweep.
- Invariant: gray_out == bin_out ^ (bin_out >> 1) in every cycle. Both are registered from the same next-value logic. No combinational path from any input to any output.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE, start=1, lo<=hi (unsigned): capture lo/hi/dir/cont into shadow regs and go to LOAD. busy=1 after this edge.
- IDLE, start=1, lo>hi: stay IDLE. err=1 for exactly the next cycle. No other output changes.
- LOAD, lasting one cycle: bin_out <= (dir ? hi : lo) and gray_out updated. valid=1 from the following cycle. Go to RUN. step_en is ignored in LOAD. Latency from start edge to first valid value is 2 edges.
- RUN, step_en=1, not at end: bin_out += 1 (up) or -= 1 (down). End is bin_out==hi for up, bin_out==lo for down.
- RUN, step_en=1, at end, cont=1: reload the start value (lo for up, hi for down). Stay in RUN; valid stays 1.
- RUN, step_en=1, at end, cont=0: go to DONE. valid=0 and busy=0 after the edge. bin_out/gray_out hold the end value.
- RUN, step_en=0: hold all outputs.
- DONE: done=1 for exactly one cycle, then IDLE. start is ignored while in DONE.
- stop=1 in LOAD or RUN: go to IDLE at the next edge. valid=0, busy=0, no done pulse. bin_out/gray_out hold their last value. stop has priority over step_en on the same edge.
- start is ignored whenever busy=1. Input changes on lo/hi/dir/cont during a sweep have no effect, because shadow regs are used.
- lo==hi: single value. With cont=0, the first step_en ends the sweep. With cont=1, the value is held at every step.
- Arithmetic is WIDTH-bit unsigned. The range check prevents any underflow/overflow: for example, lo=0 with a down sweep ends at 0 and never wraps to all-ones.

Test Plan:
- Up sweep, WIDTH=4, lo=0, hi=15, dir=0, cont=0, step_en=1 every cycle -> gray_out 0000,0001,0011,0010,0110,...,1000; done pulses once after the 16th value; valid=0 afterward.
- Down sweep, lo=3, hi=6, dir=1, cont=0 -> bin_out 6,5,4,3; gray_out 0101,0111,0110,0010; then done=1 for one cycle; bin_out holds 3.
- Continuous sweep, lo=14, hi=15, up, cont=1, 6 steps -> bin_out 14,15,14,15,...; gray_out 1001,1000,1001,...; done never asserts; busy stays 1.
- Config error, lo=9, hi=2, start=1 -> err=1 for one cycle; busy=0, valid=0, bin_out=0 unchanged.
- Mid-sweep control, lo=0, hi=15, up: start pulsed again at bin_out=4 is ignored; stop with step_en=1 at bin_out=7 -> IDLE next edge, bin_out=7, gray_out=0100, no done.
- Async reset, rst_n=0 asserted between edges during RUN at bin_out=10 -> all outputs 0 immediately. After release, a new start with lo=2, hi=3 sweeps correctly.
